sprite_fetch: RTL and testbench

- Feeds the 8-sprite shift chain (SpriteSet) for the next scanline.
- During PPU cycles 256-319 it reads the 32-byte secondary sprite buffer from the OAM evaluator's bus, 4 bytes per slot for 8 slots.
- For each slot it fetches two pattern bytes from CHR memory, then assembles and pushes one 27-bit sprite word plus load strobes into the chain.
- It is the producer for the chain's load_in/load interface.

---
 rtl/sprite_fetch.sv | 239 +++++++++++++++++++++++
 tb/tb_sprite_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch.sv
// Sprite pattern fetcher: walks the secondary sprite buffer during cycles 256-319,
// reads two CHR planes per slot and pushes one assembled word per slot into the sprite chain.
module sprite_fetch #(
    parameter int CHR_AW = 13
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic              i_fetch_en,
    input  logic [8:0]        i_cycle,
    input  logic              i_obj_size,
    input  logic              i_obj_patt,
    input  logic [7:0]        i_oam_bus,
    input  logic [7:0]        i_chr_data,
    output logic [CHR_AW-1:0] o_chr_addr,
    output logic              o_chr_rd,
    output logic [3:0]        o_load,
    output logic [26:0]       o_load_in,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]        state_q,    state_d;
    logic [2:0]        slot_q,     slot_d;
    logic [2:0]        phase_q,    phase_d;
    logic [3:0]        row_q,      row_d;
    logic              empty_q,    empty_d;
    logic [7:0]        tile_q,     tile_d;
    logic              vflip_q,    vflip_d;
    logic              hflip_q,    hflip_d;
    logic              prio_q,     prio_d;
    logic [1:0]        pal_q,      pal_d;
    logic [7:0]        x_q,        x_d;
    logic [7:0]        lo_q,       lo_d;
    logic [CHR_AW-1:0] chr_addr_q, chr_addr_d;
    logic              chr_rd_q,   chr_rd_d;
    logic [3:0]        load_q,     load_d;
    logic [26:0]       load_in_q,  load_in_d;
    logic              done_q,     done_d;

    function automatic logic [7:0] bit_rev(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // The chain emits bit0 first, so unflipped sprites need the CHR byte mirrored.
    function automatic logic [7:0] pix_of(input logic [7:0] b, input logic hflip,
                                          input logic empty);
        logic [7:0] p;
        if (empty) begin
            p = 8'h00;
        end else if (hflip) begin
            p = b;
        end else begin
            p = bit_rev(b);
        end
        return p;
    endfunction

    function automatic logic [12:0] pat_addr(input logic size, input logic patt,
                                             input logic [3:0] row, input logic [7:0] tile,
                                             input logic vflip, input logic plane);
        logic [3:0]  r;
        logic [12:0] a;
        if (vflip) begin
            r = row ^ (size ? 4'hF : 4'h7);
        end else begin
            r = row;
        end
        if (size) begin
            a = {tile[0], tile[7:1], r[3], plane, r[2:0]};
        end else begin
            a = {patt, tile, plane, r[2:0]};
        end
        return a;
    endfunction

    // Next-state and output-register logic for the IDLE/FETCH sequencer.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        phase_d    = phase_q;
        row_d      = row_q;
        empty_d    = empty_q;
        tile_d     = tile_q;
        vflip_d    = vflip_q;
        hflip_d    = hflip_q;
        prio_d     = prio_q;
        pal_d      = pal_q;
        x_d        = x_q;
        lo_d       = lo_q;
        chr_addr_d = chr_addr_q;
        chr_rd_d   = chr_rd_q;
        load_d     = 4'b0000;
        load_in_d  = load_in_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                chr_rd_d = 1'b0;
                // The trigger cycle itself doubles as slot 0, phase 0.
                if ((i_cycle == 9'd256) && i_fetch_en) begin
                    state_d = ST_FETCH;
                    slot_d  = 3'd0;
                    phase_d = 3'd1;
                    row_d   = i_oam_bus[3:0];
                    empty_d = (i_oam_bus[7:4] != 4'h0);
                end else begin
                    state_d = ST_IDLE;
                    slot_d  = 3'd0;
                    phase_d = 3'd0;
                end
            end
            ST_FETCH: begin
                if (!i_fetch_en) begin
                    state_d  = ST_IDLE;
                    slot_d   = 3'd0;
                    phase_d  = 3'd0;
                    chr_rd_d = 1'b0;
                end else begin
                    phase_d = phase_q + 3'd1;
                    if (phase_q == 3'd7) begin
                        slot_d = slot_q + 3'd1;
                    end else begin
                        slot_d = slot_q;
                    end
                    case (phase_q)
                        3'd0: begin
                            row_d   = i_oam_bus[3:0];
                            empty_d = (i_oam_bus[7:4] != 4'h0);
                        end
                        3'd1: tile_d = i_oam_bus;
                        3'd2: begin
                            vflip_d = i_oam_bus[7];
                            hflip_d = i_oam_bus[6];
                            prio_d  = i_oam_bus[5];
                            pal_d   = i_oam_bus[1:0];
                        end
                        3'd3: begin
                            x_d        = i_oam_bus;
                            chr_addr_d = CHR_AW'(pat_addr(i_obj_size, i_obj_patt, row_q,
                                                          tile_q, vflip_q, 1'b0));
                            chr_rd_d   = 1'b1;
                        end
                        3'd4: begin
                            chr_addr_d = CHR_AW'(pat_addr(i_obj_size, i_obj_patt, row_q,
                                                          tile_q, vflip_q, 1'b1));
                            chr_rd_d   = 1'b1;
                        end
                        3'd5: begin
                            lo_d     = i_chr_data;
                            chr_rd_d = 1'b0;
                        end
                        3'd6: begin
                            load_in_d = {pix_of(lo_q, hflip_q, empty_q),
                                         pix_of(i_chr_data, hflip_q, empty_q),
                                         x_q, pal_q, prio_q};
                            load_d    = 4'b1111;
                        end
                        3'd7: begin
                            if (slot_q == 3'd7) begin
                                state_d = ST_IDLE;
                                slot_d  = 3'd0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_FETCH;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                state_d  = ST_IDLE;
                slot_d   = 3'd0;
                phase_d  = 3'd0;
                chr_rd_d = 1'b0;
            end
        endcase
    end

    // State and output registers; everything holds while the clock enable is low.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            slot_q     <= 3'd0;
            phase_q    <= 3'd0;
            row_q      <= 4'h0;
            empty_q    <= 1'b0;
            tile_q     <= 8'h00;
            vflip_q    <= 1'b0;
            hflip_q    <= 1'b0;
            prio_q     <= 1'b0;
            pal_q      <= 2'b00;
            x_q        <= 8'h00;
            lo_q       <= 8'h00;
            chr_addr_q <= '0;
            chr_rd_q   <= 1'b0;
            load_q     <= 4'b0000;
            load_in_q  <= 27'd0;
            done_q     <= 1'b0;
        end else if (i_ce) begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            phase_q    <= phase_d;
            row_q      <= row_d;
            empty_q    <= empty_d;
            tile_q     <= tile_d;
            vflip_q    <= vflip_d;
            hflip_q    <= hflip_d;
            prio_q     <= prio_d;
            pal_q      <= pal_d;
            x_q        <= x_d;
            lo_q       <= lo_d;
            chr_addr_q <= chr_addr_d;
            chr_rd_q   <= chr_rd_d;
            load_q     <= load_d;
            load_in_q  <= load_in_d;
            done_q     <= done_d;
        end
    end

    assign o_chr_addr = chr_addr_q;
    assign o_chr_rd   = chr_rd_q;
    assign o_load     = load_q;
    assign o_load_in  = load_in_q;
    assign o_busy     = (state_q == ST_FETCH);
    assign o_done     = done_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch: per-line vectors for slot 0 plus abort, ce-gating and reset sequences.
module tb_sprite_fetch;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_ce;
    logic        i_fetch_en;
    logic [8:0]  i_cycle;
    logic        i_obj_size;
    logic        i_obj_patt;
    logic [7:0]  i_oam_bus;
    logic [7:0]  i_chr_data;
    logic [12:0] o_chr_addr;
    logic        o_chr_rd;
    logic [3:0]  o_load;
    logic [26:0] o_load_in;
    logic        o_busy;
    logic        o_done;

    sprite_fetch #(.CHR_AW(13)) dut (
        .clk(clk), .i_rst(i_rst), .i_ce(i_ce), .i_fetch_en(i_fetch_en),
        .i_cycle(i_cycle), .i_obj_size(i_obj_size), .i_obj_patt(i_obj_patt),
        .i_oam_bus(i_oam_bus), .i_chr_data(i_chr_data), .o_chr_addr(o_chr_addr),
        .o_chr_rd(o_chr_rd), .o_load(o_load), .o_load_in(o_load_in),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        size;
        logic        patt;
        logic [7:0]  row, tile, attr, x;
        logic [7:0]  chr_lo, chr_hi;
        logic [12:0] a_lo, a_hi;
        logic [26:0] exp_word;
    } vec_t;

    vec_t        vecs [6];
    vec_t        cur;
    logic [7:0]  oam_tbl [32];
    logic        prev_rd;
    logic [12:0] prev_addr;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // CHR model: only the two addresses of the current vector hold known data.
    function automatic logic [7:0] chr_mem(input logic [12:0] a);
        if (a == cur.a_lo) return cur.chr_lo;
        else if (a == cur.a_hi) return cur.chr_hi;
        else return 8'hEE;
    endfunction

    task automatic setup_line(input int vi);
        cur        = vecs[vi];
        i_obj_size = cur.size;
        i_obj_patt = cur.patt;
        for (int k = 0; k < 32; k++) oam_tbl[k] = 8'hFF;
        oam_tbl[0] = cur.row;
        oam_tbl[1] = cur.tile;
        oam_tbl[2] = cur.attr;
        oam_tbl[3] = cur.x;
        prev_rd    = 1'b0;
        prev_addr  = 13'd0;
    endtask

    task automatic drive_cycle(input int c, input logic en);
        i_ce       = 1'b1;
        i_cycle    = 9'(c);
        i_fetch_en = en;
        i_oam_bus  = (c >= 256 && c <= 319) ? oam_tbl[c-256] : 8'h00;
        i_chr_data = prev_rd ? chr_mem(prev_addr) : 8'h00;
    endtask

    // One ce-high cycle, optionally followed by a ce-low cycle with hostile inputs.
    task automatic step(input bit ce_tog);
        logic [19:0] snap;
        logic [26:0] snap_li;
        prev_rd   = o_chr_rd;
        prev_addr = o_chr_addr;
        @(posedge clk); #1;
        if (ce_tog) begin
            snap    = {o_load, o_chr_rd, o_busy, o_done, o_chr_addr};
            snap_li = o_load_in;
            i_ce       = 1'b0;
            i_cycle    = 9'd256;
            i_oam_bus  = 8'h00;
            i_chr_data = 8'h00;
            @(posedge clk); #1;
            check("hold_ctl", 32'({o_load, o_chr_rd, o_busy, o_done, o_chr_addr}), 32'(snap));
            check("hold_word", 32'(o_load_in), 32'(snap_li));
            i_ce = 1'b1;
        end
    endtask

    task automatic run_line(input int vi, input bit ce_tog, input int drop);
        int n_load;
        int n_done;
        int exp_loads;
        setup_line(vi);
        n_load    = 0;
        n_done    = 0;
        exp_loads = 0;
        for (int k = 0; k < 8; k++) if (drop == 0 || 263 + 8*k <= drop) exp_loads++;
        for (int c = 250; c <= 330; c++) begin
            drive_cycle(c, (drop == 0) || (c < drop));
            if (drop == 0 || drop > 263) begin
                if (c == 260) begin
                    check("rd_k4", 32'(o_chr_rd), 32'd1);
                    check("addr_lo", 32'(o_chr_addr), 32'(cur.a_lo));
                end
                if (c == 261) begin
                    check("rd_k5", 32'(o_chr_rd), 32'd1);
                    check("addr_hi", 32'(o_chr_addr), 32'(cur.a_hi));
                end
                if (c == 262) check("rd_k6", 32'(o_chr_rd), 32'd0);
                if (c == 263) begin
                    check("load_k7", 32'(o_load), 32'hF);
                    check("word_k7", 32'(o_load_in), 32'(cur.exp_word));
                end
            end
            if (c == 256) check("busy_idle", 32'(o_busy), 32'd0);
            if (c == 257) check("busy_start", 32'(o_busy), (drop == 0 || drop > 256) ? 32'd1 : 32'd0);
            if (c == 300) check("busy_mid", 32'(o_busy), (drop == 0) ? 32'd1 : 32'd0);
            if (c == 319 && drop == 0) check("slot7_word", 32'(o_load_in), 32'h7FF);
            if (o_load != 4'd0) begin
                check("load_bits", 32'(o_load), 32'hF);
                check("load_cycle", 32'(c), 32'(263 + 8*n_load));
                n_load++;
            end
            if (o_done) begin
                check("done_cycle", 32'(c), 32'd320);
                n_done++;
            end
            step(ce_tog);
        end
        check("load_count", 32'(n_load), 32'(exp_loads));
        check("done_count", 32'(n_done), (drop == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        //            size  patt  row    tile   attr   x      lo     hi     a_lo      a_hi      word
        vecs[0] = '{1'b0, 1'b1, 8'h03, 8'h42, 8'h21, 8'h80, 8'h81, 8'h0F, 13'h1423, 13'h142B, {8'h81, 8'hF0, 8'h80, 2'b01, 1'b1}};
        vecs[1] = '{1'b1, 1'b0, 8'h02, 8'h43, 8'hC0, 8'h10, 8'hA5, 8'h3C, 13'h1435, 13'h143D, {8'hA5, 8'h3C, 8'h10, 2'b00, 1'b0}};
        vecs[2] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'h83, 8'hFF, 8'h01, 8'h80, 13'h0002, 13'h000A, {8'h80, 8'h01, 8'hFF, 2'b11, 1'b0}};
        vecs[3] = '{1'b1, 1'b0, 8'h0A, 8'hFE, 8'h02, 8'h00, 8'hF0, 8'h12, 13'h0FF2, 13'h0FFA, {8'h0F, 8'h48, 8'h00, 2'b10, 1'b0}};
        vecs[4] = '{1'b0, 1'b1, 8'hF0, 8'h42, 8'h21, 8'h33, 8'hFF, 8'hFF, 13'h1420, 13'h1428, {8'h00, 8'h00, 8'h33, 2'b01, 1'b1}};
        vecs[5] = '{1'b0, 1'b0, 8'h0C, 8'h10, 8'h40, 8'h08, 8'h55, 8'hAA, 13'h0104, 13'h010C, {8'h55, 8'hAA, 8'h08, 2'b00, 1'b0}};

        i_rst = 1'b1; i_ce = 1'b1; i_fetch_en = 1'b1; i_cycle = 9'd0;
        i_obj_size = 1'b0; i_obj_patt = 1'b0; i_oam_bus = 8'h00; i_chr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_load", 32'(o_load), 32'd0);
        check("rst_rd", 32'(o_chr_rd), 32'd0);
        check("rst_addr", 32'(o_chr_addr), 32'd0);
        check("rst_word", 32'(o_load_in), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) run_line(v, 1'b0, 0);

        run_line(0, 1'b0, 290);
        run_line(0, 1'b0, 0);
        run_line(1, 1'b0, 1);
        run_line(0, 1'b1, 0);

        // Asynchronous reset in the middle of slot 0, then a quiet remainder of the line.
        setup_line(0);
        begin
            int n_act;
            n_act = 0;
            for (int c = 250; c <= 330; c++) begin
                drive_cycle(c, 1'b1);
                if (c == 260) begin
                    check("pre_rst_rd", 32'(o_chr_rd), 32'd1);
                    #3 i_rst = 1'b1;
                    #1;
                    check("arst_load", 32'(o_load), 32'd0);
                    check("arst_rd", 32'(o_chr_rd), 32'd0);
                    check("arst_addr", 32'(o_chr_addr), 32'd0);
                    check("arst_word", 32'(o_load_in), 32'd0);
                    check("arst_busy", 32'(o_busy), 32'd0);
                    check("arst_done", 32'(o_done), 32'd0);
                    #1 i_rst = 1'b0;
                end
                if (c > 260 && (o_load != 4'd0 || o_chr_rd || o_busy || o_done)) n_act++;
                step(1'b0);
            end
            check("post_rst_quiet", 32'(n_act), 32'd0);
        end
        run_line(2, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
